// File: rtl/spi_tgt_regs.sv
// spi_tgt_regs: SPI mode-0 target serving burst reads/writes to a local byte register file
module spi_tgt_regs #(
  parameter int REG_NUM = 16,
  localparam int ADDR_WIDTH = $clog2(REG_NUM)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_nss_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_en_o,
  input  logic                  loc_we_i,
  input  logic [ADDR_WIDTH-1:0] loc_addr_i,
  input  logic [7:0]            loc_wdata_i,
  output logic [7:0]            loc_rdata_o,
  output logic                  wr_vld_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [7:0]            wr_data_o,
  output logic                  irq_o,
  input  logic                  irq_clr_i
);
  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;
  state_t state_q, state_d;
  logic [2:0] sck_q, nss_q;
  logic [1:0] mosi_q;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d, wr_data_q, wr_data_d, rx_byte;
  logic [7:0] regs_q [REG_NUM];
  logic [7:0] regs_d [REG_NUM];
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d, cmd_addr;
  logic miso_q, miso_d, en_q, ign_q, wrote_q, wrote_d, irq_q, irq_d, wr_vld_q, wr_vld_d;
  logic rise, fall, nss_act, nss_off, byte_done;
  assign rise = sck_q[1] & ~sck_q[2];
  assign fall = ~sck_q[1] & sck_q[2];
  assign nss_act = ~nss_q[1];
  assign nss_off = nss_q[1] & ~nss_q[2];
  assign rx_byte = {rx_q[6:0], mosi_q[1]};
  assign byte_done = rise && cnt_q == 3'd7;
  assign cmd_addr = rx_byte[ADDR_WIDTH-1:0];
  always_comb begin
    state_d = state_q;
    cnt_d = rise ? cnt_q + 3'd1 : cnt_q;
    rx_d = rise ? rx_byte : rx_q;
    tx_d = tx_q;
    miso_d = miso_q;
    addr_d = addr_q;
    wrote_d = wrote_q;
    wr_vld_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    irq_d = (nss_off & wrote_q) | (irq_q & ~irq_clr_i);
    regs_d = regs_q;
    if (loc_we_i) regs_d[loc_addr_i] = loc_wdata_i;
    case (state_q)
      IDLE: if (nss_act && !ign_q) begin
        state_d = CMD;
        cnt_d = 3'd0;
        wrote_d = 1'b0;
      end
      CMD: if (byte_done) begin
        state_d = rx_byte[7] ? RD : WR;
        tx_d = regs_q[cmd_addr];
        addr_d = rx_byte[7] ? cmd_addr + ADDR_WIDTH'(1) : cmd_addr;
      end
      WR: if (byte_done) begin
        // SPI commit is applied after the local write so it wins on an address clash
        regs_d[addr_q] = rx_byte;
        wr_vld_d = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = rx_byte;
        wrote_d = 1'b1;
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
      RD: begin
        if (fall) begin
          miso_d = tx_q[7];
          tx_d = {tx_q[6:0], 1'b0};
        end
        if (byte_done) begin
          tx_d = regs_q[addr_q];
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
    endcase
    if (nss_off) begin
      state_d = IDLE;
      miso_d = 1'b0;
    end
  end
  // NSS sync flops reset to "active" so a frame still open at reset release never looks like a new start
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sck_q <= '0;
      nss_q <= '0;
      mosi_q <= '0;
      ign_q <= 1'b1;
      en_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      miso_q <= 1'b0;
      addr_q <= '0;
      wrote_q <= 1'b0;
      wr_vld_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      irq_q <= 1'b0;
      regs_q <= '{default: '0};
    end else begin
      sck_q <= {sck_q[1:0], spi_sck_i};
      nss_q <= {nss_q[1:0], spi_nss_i};
      mosi_q <= {mosi_q[0], spi_mosi_i};
      ign_q <= ign_q & nss_act;
      en_q <= nss_act & ~ign_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      miso_q <= miso_d;
      addr_q <= addr_d;
      wrote_q <= wrote_d;
      wr_vld_q <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      irq_q <= irq_d;
      regs_q <= regs_d;
    end
  end
  assign spi_miso_o = miso_q;
  assign spi_miso_en_o = en_q;
  assign loc_rdata_o = regs_q[loc_addr_i];
  assign wr_vld_o = wr_vld_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign irq_o = irq_q;
endmodule

// File: tb/tb_spi_tgt_regs.sv
// tb_spi_tgt_regs: directed vector bench for the SPI target register file
module tb_spi_tgt_regs;
  logic clk = 0, rst_n = 0, sck = 0, nss = 1, mosi = 0, loc_we = 0, irq_clr = 0;
  logic [3:0] loc_addr = 0, wr_addr;
  logic [7:0] loc_wdata = 0, wr_data, loc_rdata;
  logic miso, miso_en, wr_vld, irq;
  int nvec = 0, nerr = 0;
  logic [11:0] wv_q[$];
  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t lv[9] = '{
    '{1'b0, 4'd0,  8'h00, 8'h00},
    '{1'b0, 4'd15, 8'h00, 8'h00},
    '{1'b1, 4'd1,  8'h3C, 8'h3C},
    '{1'b1, 4'd9,  8'hC3, 8'hC3},
    '{1'b0, 4'd1,  8'h00, 8'h3C},
    '{1'b1, 4'd1,  8'hFF, 8'hFF},
    '{1'b0, 4'd9,  8'h00, 8'hC3},
    '{1'b0, 4'd2,  8'h00, 8'h00},
    '{1'b1, 4'd9,  8'h00, 8'h00}
  };
  vec_t rb[10] = '{
    '{1'b0, 4'd0,  8'h00, 8'h22},
    '{1'b0, 4'd1,  8'h00, 8'hFF},
    '{1'b0, 4'd2,  8'h00, 8'h77},
    '{1'b0, 4'd3,  8'h00, 8'hA5},
    '{1'b0, 4'd4,  8'h00, 8'h5A},
    '{1'b0, 4'd5,  8'h00, 8'h00},
    '{1'b0, 4'd6,  8'h00, 8'h44},
    '{1'b0, 4'd7,  8'h00, 8'h99},
    '{1'b0, 4'd9,  8'h00, 8'h00},
    '{1'b0, 4'd15, 8'h00, 8'h11}
  };

  always #5 clk = ~clk;

  spi_tgt_regs dut (
    .clk_i(clk), .rst_n_i(rst_n), .spi_sck_i(sck), .spi_nss_i(nss), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_en_o(miso_en), .loc_we_i(loc_we), .loc_addr_i(loc_addr),
    .loc_wdata_i(loc_wdata), .loc_rdata_o(loc_rdata), .wr_vld_o(wr_vld), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .irq_o(irq), .irq_clr_i(irq_clr)
  );

  always @(negedge clk) if (wr_vld === 1'b1) wv_q.push_back({wr_addr, wr_data});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    loc_we = v.we;
    loc_addr = v.addr;
    loc_wdata = v.wdata;
    @(negedge clk);
    loc_we = 0;
    #1 chk($sformatf("reg[%0d]", v.addr), loc_rdata, v.exp);
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [7:0] exp);
    loc_addr = a;
    #1 chk($sformatf("rd reg[%0d]", a), loc_rdata, exp);
  endtask

  task automatic wv_pop(input string name, input logic [11:0] exp);
    logic [11:0] e;
    e = 12'hFFF;
    if (wv_q.size() > 0) e = wv_q.pop_front();
    chk(name, e, exp);
  endtask

  task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] r);
    r = 0;
    for (int i = 0; i < n; i++) begin
      mosi = d[7-i];
      repeat (5) @(negedge clk);
      r = {r[6:0], miso};
      sck = 1;
      repeat (5) @(negedge clk);
      sck = 0;
    end
  endtask

  task automatic start();
    nss = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic stop(input logic clr_same);
    repeat (6) @(negedge clk);
    nss = 1;
    repeat (2) @(negedge clk);
    irq_clr = clr_same;
    @(negedge clk);
    irq_clr = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic clr_irq();
    irq_clr = 1;
    @(negedge clk);
    irq_clr = 0;
    @(negedge clk);
  endtask

  task automatic collide(input logic [3:0] la);
    logic [7:0] r;
    start();
    spi_bits(8'h06, 8, r);
    spi_bits(8'h44, 7, r);
    mosi = 0;
    repeat (5) @(negedge clk);
    sck = 1;
    repeat (2) @(negedge clk);
    loc_we = 1;
    loc_addr = la;
    loc_wdata = 8'h99;
    @(negedge clk);
    loc_we = 0;
    repeat (2) @(negedge clk);
    sck = 0;
    stop(0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    repeat (2) @(negedge clk);
    chk("rst miso", miso, 0);
    chk("rst miso_en", miso_en, 0);
    chk("rst wr_vld", wr_vld, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst irq", irq, 0);
    for (int i = 0; i < 16; i++) rd_chk(4'(i), 8'h00);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("idle miso_en", miso_en, 0);
    foreach (lv[i]) apply_vec(lv[i]);

    start();
    chk("wr miso_en", miso_en, 1);
    spi_bits(8'h03, 8, r);
    spi_bits(8'hA5, 8, r);
    spi_bits(8'h5A, 8, r);
    stop(1);
    chk("irq set beats clr", irq, 1);
    chk("miso_en off", miso_en, 0);
    wv_pop("wv0", {4'd3, 8'hA5});
    wv_pop("wv1", {4'd4, 8'h5A});
    chk("wv extra", wv_q.size(), 0);
    rd_chk(3, 8'hA5);
    rd_chk(4, 8'h5A);
    clr_irq();
    chk("irq cleared", irq, 0);

    apply_vec('{1'b1, 4'd15, 8'h11, 8'h11});
    apply_vec('{1'b1, 4'd0, 8'h22, 8'h22});
    start();
    spi_bits(8'h8F, 8, r);
    chk("rd cmd miso", r, 8'h00);
    spi_bits(8'h00, 8, r);
    chk("rd byte0", r, 8'h11);
    spi_bits(8'h00, 8, r);
    chk("rd byte1 wrap", r, 8'h22);
    repeat (6) @(negedge clk);
    chk("rd next msb", miso, 1);
    stop(0);
    chk("rd miso idle", miso, 0);
    chk("rd irq", irq, 0);
    chk("rd no wv", wv_q.size(), 0);
    rd_chk(15, 8'h11);

    start();
    spi_bits(8'h02, 8, r);
    spi_bits(8'hB0, 5, r);
    stop(0);
    rd_chk(2, 8'h00);
    chk("abort no wv", wv_q.size(), 0);
    chk("abort irq", irq, 0);
    chk("abort miso_en", miso_en, 0);
    start();
    spi_bits(8'h02, 8, r);
    spi_bits(8'h77, 8, r);
    stop(0);
    rd_chk(2, 8'h77);
    wv_pop("wv after abort", {4'd2, 8'h77});
    chk("irq after abort", irq, 1);
    clr_irq();

    collide(4'd6);
    rd_chk(6, 8'h44);
    wv_pop("wv collide", {4'd6, 8'h44});
    clr_irq();
    apply_vec('{1'b1, 4'd6, 8'h00, 8'h00});
    collide(4'd7);
    rd_chk(6, 8'h44);
    rd_chk(7, 8'h99);
    wv_pop("wv collide2", {4'd6, 8'h44});
    clr_irq();
    foreach (rb[i]) apply_vec(rb[i]);

    start();
    spi_bits(8'h0A, 8, r);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    spi_bits(8'hEE, 8, r);
    repeat (6) @(negedge clk);
    rd_chk(10, 8'h00);
    rd_chk(2, 8'h00);
    chk("rstmid no wv", wv_q.size(), 0);
    stop(0);
    chk("rstmid irq", irq, 0);
    start();
    spi_bits(8'h0A, 8, r);
    spi_bits(8'hEE, 8, r);
    stop(0);
    rd_chk(10, 8'hEE);
    wv_pop("wv after rst", {4'd10, 8'hEE});
    chk("irq after rst", irq, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
